// File: rtl/router_pkg.sv
// Shared state and address encodings for the 1x3 router control path.
// Defining ROUTER_FSM_ADDR_DROP_EN widens the state code by one bit to make room for DROP_PACKET.
package router_pkg;

`ifdef ROUTER_FSM_ADDR_DROP_EN
   localparam int STATE_W = 4;
`else
   localparam int STATE_W = 3;
`endif

   typedef enum logic [STATE_W-1:0] {
      DECODE_ADDRESS     = STATE_W'(0),
      LOAD_FIRST_DATA    = STATE_W'(1),
      LOAD_DATA          = STATE_W'(2),
      LOAD_PARITY        = STATE_W'(3),
      FIFO_FULL_STATE    = STATE_W'(4),
      LOAD_AFTER_FULL    = STATE_W'(5),
      WAIT_TILL_EMPTY    = STATE_W'(6),
      CHECK_PARITY_ERROR = STATE_W'(7)
`ifdef ROUTER_FSM_ADDR_DROP_EN
      , DROP_PACKET      = STATE_W'(8)
`endif
   } state_t;

   localparam logic [1:0] ADDR_P0      = 2'd0;
   localparam logic [1:0] ADDR_P1      = 2'd1;
   localparam logic [1:0] ADDR_P2      = 2'd2;
   localparam logic [1:0] ADDR_INVALID = 2'd3;

   // Selects the per-port flag for a header address; the invalid address maps to 0.
   function automatic logic port_bit(input logic [2:0] vec, input logic [1:0] addr);
      logic sel;
      case (addr)
         ADDR_P0: sel = vec[0];
         ADDR_P1: sel = vec[1];
         ADDR_P2: sel = vec[2];
         default: sel = 1'b0;
      endcase
      return sel;
   endfunction

endpackage

// File: rtl/router_fsm.sv
// Packet-control FSM of the 1x3 router: decodes the header, paces writes and raises busy.
// Optional ROUTER_FSM_ADDR_DROP_EN: headers for address 3 are swallowed in DROP_PACKET.
module router_fsm
   import router_pkg::*;
(
   input  logic               clock,
   input  logic               resetn,
   input  logic               pkt_valid,
   input  logic [1:0]         data_in,
   input  logic               parity_done,
   input  logic               low_pkt_valid,
   input  logic               fifo_full,
   input  logic               fifo_empty_0,
   input  logic               fifo_empty_1,
   input  logic               fifo_empty_2,
   input  logic               soft_reset_0,
   input  logic               soft_reset_1,
   input  logic               soft_reset_2,
   output logic               detect_add,
   output logic               lfd_state,
   output logic               ld_state,
   output logic               laf_state,
   output logic               full_state,
   output logic               write_enb_reg,
   output logic               rst_int_reg,
   output logic               busy,
   output logic [STATE_W-1:0] state_dbg
);

   state_t     state;
   state_t     next_state;
   logic [1:0] addr_q;
   logic [2:0] fifo_empty_vec;
   logic [2:0] soft_reset_vec;
   logic       soft_hit;
   logic       soft_exempt;

   assign fifo_empty_vec = {fifo_empty_2, fifo_empty_1, fifo_empty_0};
   assign soft_reset_vec = {soft_reset_2, soft_reset_1, soft_reset_0};
   assign soft_hit       = port_bit(soft_reset_vec, addr_q);
   assign state_dbg      = state;

`ifdef ROUTER_FSM_ADDR_DROP_EN
   assign soft_exempt = (state == DECODE_ADDRESS) || (state == DROP_PACKET);
`else
   assign soft_exempt = (state == DECODE_ADDRESS);
`endif

   always_comb begin
      next_state = DECODE_ADDRESS;
      case (state)
         DECODE_ADDRESS: begin
            if (pkt_valid && data_in != ADDR_INVALID)
               next_state = port_bit(fifo_empty_vec, data_in) ? LOAD_FIRST_DATA : WAIT_TILL_EMPTY;
`ifdef ROUTER_FSM_ADDR_DROP_EN
            else if (pkt_valid)
               next_state = DROP_PACKET;
`endif
            else
               next_state = DECODE_ADDRESS;
         end
         WAIT_TILL_EMPTY:
            next_state = port_bit(fifo_empty_vec, addr_q) ? LOAD_FIRST_DATA : WAIT_TILL_EMPTY;
         LOAD_FIRST_DATA:
            next_state = LOAD_DATA;
         LOAD_DATA: begin
            if (fifo_full)
               next_state = FIFO_FULL_STATE;
            else if (!pkt_valid)
               next_state = LOAD_PARITY;
            else
               next_state = LOAD_DATA;
         end
         FIFO_FULL_STATE:
            next_state = fifo_full ? FIFO_FULL_STATE : LOAD_AFTER_FULL;
         LOAD_AFTER_FULL: begin
            if (parity_done)
               next_state = DECODE_ADDRESS;
            else if (low_pkt_valid)
               next_state = LOAD_PARITY;
            else
               next_state = LOAD_DATA;
         end
         LOAD_PARITY:
            next_state = CHECK_PARITY_ERROR;
         CHECK_PARITY_ERROR:
            next_state = fifo_full ? FIFO_FULL_STATE : DECODE_ADDRESS;
`ifdef ROUTER_FSM_ADDR_DROP_EN
         DROP_PACKET:
            next_state = pkt_valid ? DROP_PACKET : DECODE_ADDRESS;
`endif
         default:
            next_state = DECODE_ADDRESS;
      endcase
      // A timeout on the addressed port abandons the packet from any active state.
      if (!soft_exempt && soft_hit)
         next_state = DECODE_ADDRESS;
   end

   // Outputs are registered from next_state so they always equal the decode of state.
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         state         <= DECODE_ADDRESS;
         addr_q        <= ADDR_P0;
         detect_add    <= 1'b1;
         lfd_state     <= 1'b0;
         ld_state      <= 1'b0;
         laf_state     <= 1'b0;
         full_state    <= 1'b0;
         write_enb_reg <= 1'b0;
         rst_int_reg   <= 1'b0;
         busy          <= 1'b0;
      end else begin
         state <= next_state;
         if (state == DECODE_ADDRESS && pkt_valid)
            addr_q <= data_in;
         detect_add    <= (next_state == DECODE_ADDRESS);
         lfd_state     <= (next_state == LOAD_FIRST_DATA);
         ld_state      <= (next_state == LOAD_DATA);
         laf_state     <= (next_state == LOAD_AFTER_FULL);
         full_state    <= (next_state == FIFO_FULL_STATE);
         write_enb_reg <= (next_state inside {LOAD_DATA, LOAD_PARITY, LOAD_AFTER_FULL});
         rst_int_reg   <= (next_state == CHECK_PARITY_ERROR);
         busy          <= (next_state inside {LOAD_FIRST_DATA, LOAD_PARITY, FIFO_FULL_STATE,
                                              LOAD_AFTER_FULL, WAIT_TILL_EMPTY, CHECK_PARITY_ERROR});
      end
   end

endmodule

// File: tb/tb_router_fsm.sv
// Bench for router_fsm: packet-level scenarios expand into per-cycle expected states.
// Define ROUTER_FSM_ADDR_DROP_EN for both bench and RTL to cover address-3 dropping.
module tb_router_fsm;
   import router_pkg::*;

   logic               clock = 1'b0;
   logic               resetn = 1'b1;
   logic               pkt_valid = 1'b0;
   logic [1:0]         data_in = 2'd0;
   logic               parity_done = 1'b0;
   logic               low_pkt_valid = 1'b0;
   logic               fifo_full = 1'b0;
   logic [2:0]         fifo_empty = 3'b111;
   logic [2:0]         soft_reset = 3'b000;
   logic               detect_add, lfd_state, ld_state, laf_state, full_state;
   logic               write_enb_reg, rst_int_reg, busy;
   logic [STATE_W-1:0] state_dbg;

   logic [STATE_W-1:0] exp_q[$];
   logic [1:0]         cur_addr = 2'd0;
   int                 n_vec = 0;
   int                 n_err = 0;

   router_fsm dut (
      .clock(clock), .resetn(resetn), .pkt_valid(pkt_valid), .data_in(data_in),
      .parity_done(parity_done), .low_pkt_valid(low_pkt_valid), .fifo_full(fifo_full),
      .fifo_empty_0(fifo_empty[0]), .fifo_empty_1(fifo_empty[1]), .fifo_empty_2(fifo_empty[2]),
      .soft_reset_0(soft_reset[0]), .soft_reset_1(soft_reset[1]), .soft_reset_2(soft_reset[2]),
      .detect_add(detect_add), .lfd_state(lfd_state), .ld_state(ld_state), .laf_state(laf_state),
      .full_state(full_state), .write_enb_reg(write_enb_reg), .rst_int_reg(rst_int_reg),
      .busy(busy), .state_dbg(state_dbg)
   );

   always #5 clock = ~clock;

   // Output table: {detect_add, lfd, ld, laf, full, write_enb_reg, rst_int_reg, busy}.
   function automatic logic [7:0] out_model(input logic [STATE_W-1:0] s);
      logic [7:0] o;
      o = 8'b0;
      if (s == DECODE_ADDRESS)     o = 8'b1000_0000;
      if (s == LOAD_FIRST_DATA)    o = 8'b0100_0001;
      if (s == LOAD_DATA)          o = 8'b0010_0100;
      if (s == LOAD_AFTER_FULL)    o = 8'b0001_0101;
      if (s == FIFO_FULL_STATE)    o = 8'b0000_1001;
      if (s == LOAD_PARITY)        o = 8'b0000_0101;
      if (s == CHECK_PARITY_ERROR) o = 8'b0000_0011;
      if (s == WAIT_TILL_EMPTY)    o = 8'b0000_0001;
      return o;
   endfunction

   task automatic check_state(input string tag, input logic [STATE_W-1:0] exp);
      logic [7:0] exp_o;
      logic [7:0] act_o;
      exp_o = out_model(exp);
      act_o = {detect_add, lfd_state, ld_state, laf_state, full_state, write_enb_reg, rst_int_reg, busy};
      n_vec++;
      assert (state_dbg === exp) else begin
         n_err++;
         $error("FAIL %s state: observed %0d expected %0d", tag, state_dbg, exp);
      end
      n_vec++;
      assert (act_o === exp_o) else begin
         n_err++;
         $error("FAIL %s outputs: observed %b expected %b", tag, act_o, exp_o);
      end
   endtask

   // Inputs are already set; clock once and check the state reached.
   task automatic step(input string tag, input logic [STATE_W-1:0] exp);
      exp_q.push_back(exp);
      @(posedge clock);
      #1;
      check_state(tag, exp_q.pop_front());
   endtask

   // Randomise everything the current state ignores; the addressed soft reset stays low.
   task automatic noise();
      data_in       = 2'($urandom_range(0, 3));
      pkt_valid     = 1'($urandom_range(0, 1));
      parity_done   = 1'($urandom_range(0, 1));
      low_pkt_valid = 1'($urandom_range(0, 1));
      fifo_full     = 1'($urandom_range(0, 1));
      for (int i = 0; i < 3; i++) begin
         if (2'(i) != cur_addr) begin
            soft_reset[i] = 1'($urandom_range(0, 1));
            fifo_empty[i] = 1'($urandom_range(0, 1));
         end else begin
            soft_reset[i] = 1'b0;
         end
      end
   endtask

   task automatic idle();
      noise();
      pkt_valid = 1'b0;
      step("idle", DECODE_ADDRESS);
   endtask

   task automatic header3(input int body);
      cur_addr = ADDR_INVALID;
      noise();
      pkt_valid = 1'b1;
      data_in   = ADDR_INVALID;
`ifdef ROUTER_FSM_ADDR_DROP_EN
      step("drop_hdr", DROP_PACKET);
      for (int i = 0; i < body; i++) begin
         noise();
         pkt_valid  = 1'b1;
         soft_reset = 3'($urandom_range(0, 7));
         step("drop_body", DROP_PACKET);
      end
      noise();
      pkt_valid = 1'b0;
      step("drop_end", DECODE_ADDRESS);
`else
      step("addr3_ignored", DECODE_ADDRESS);
      for (int i = 0; i < body; i++) idle();
`endif
   endtask

   // One packet: wait_n WAIT cycles, n_ld extra LD cycles, optional full episode at
   // LD index full_at, optional addressed soft reset at LD index sr_at, optional
   // fifo_full seen in CHECK_PARITY_ERROR (then closed by parity_done in LAF).
   task automatic send_packet(input logic [1:0] addr, input int wait_n, input int n_ld,
                              input int full_at, input int full_n, input bit low_after_full,
                              input int sr_at, input bit cpe_full);
      bit to_parity;
      to_parity = 1'b0;
      cur_addr  = addr;
      noise();
      pkt_valid        = 1'b1;
      data_in          = addr;
      fifo_empty[addr] = (wait_n == 0);
      step("header", (wait_n == 0) ? LOAD_FIRST_DATA : WAIT_TILL_EMPTY);
      for (int i = 0; i < wait_n; i++) begin
         noise();
         pkt_valid        = 1'b1;
         fifo_empty[addr] = (i == wait_n - 1);
         step("wait", (i == wait_n - 1) ? LOAD_FIRST_DATA : WAIT_TILL_EMPTY);
      end
      noise();
      step("lfd", LOAD_DATA);
      for (int i = 0; i < n_ld; i++) begin
         noise();
         pkt_valid = 1'b1;
         if (i == sr_at) begin
            soft_reset[addr] = 1'b1;
            step("soft_reset", DECODE_ADDRESS);
            soft_reset[addr] = 1'b0;
            return;
         end
         if (i == full_at) begin
            fifo_full = 1'b1;
            step("full_enter", FIFO_FULL_STATE);
            for (int j = 1; j < full_n; j++) begin
               noise();
               fifo_full = 1'b1;
               step("full_hold", FIFO_FULL_STATE);
            end
            noise();
            fifo_full = 1'b0;
            step("full_exit", LOAD_AFTER_FULL);
            noise();
            parity_done   = 1'b0;
            low_pkt_valid = low_after_full;
            if (low_after_full) begin
               step("laf_low", LOAD_PARITY);
               to_parity = 1'b1;
               break;
            end
            step("laf_resume", LOAD_DATA);
         end else begin
            fifo_full = 1'b0;
            if (i == 0) soft_reset[(addr + 2'd1) % 3] = 1'b1;
            step("ld", LOAD_DATA);
         end
      end
      if (!to_parity) begin
         noise();
         pkt_valid = 1'b0;
         fifo_full = 1'b0;
         step("ld_end", LOAD_PARITY);
      end
      noise();
      step("parity", CHECK_PARITY_ERROR);
      noise();
      fifo_full = cpe_full;
      if (cpe_full) begin
         step("cpe_full", FIFO_FULL_STATE);
         noise();
         fifo_full = 1'b0;
         step("cpe_full_exit", LOAD_AFTER_FULL);
         noise();
         parity_done = 1'b1;
         step("laf_parity_done", DECODE_ADDRESS);
      end else begin
         step("cpe_done", DECODE_ADDRESS);
      end
   endtask

   initial begin
      int n_ld, full_at, sr_at, wait_n;

      // Asynchronous reset before any clock edge.
      #2 resetn = 1'b0;
      #1 check_state("reset_async", DECODE_ADDRESS);
      repeat (2) @(posedge clock);
      #1 check_state("reset_held", DECODE_ADDRESS);
      resetn = 1'b1;
      idle();

      // Directed scenarios.
      send_packet(2'd1, 0, 2, -1, 0, 1'b0, -1, 1'b0);
      idle();
      send_packet(2'd2, 5, 1, -1, 0, 1'b0, -1, 1'b0);
      send_packet(2'd0, 0, 3, 1, 4, 1'b1, -1, 1'b0);
      send_packet(2'd1, 0, 3, 0, 2, 1'b0, -1, 1'b1);
      send_packet(2'd0, 0, 3, -1, 0, 1'b0, 1, 1'b0);
      send_packet(2'd2, 2, 4, 2, 1, 1'b0, 3, 1'b0);
      header3(3);

      // Reset dropped mid-cycle while in FIFO_FULL_STATE.
      cur_addr = 2'd0;
      noise();
      pkt_valid = 1'b1; data_in = 2'd0; fifo_empty[0] = 1'b1;
      step("rst_hdr", LOAD_FIRST_DATA);
      noise();
      step("rst_lfd", LOAD_DATA);
      noise();
      fifo_full = 1'b1;
      step("rst_full", FIFO_FULL_STATE);
      #2 resetn = 1'b0;
      #1 check_state("rst_midpacket", DECODE_ADDRESS);
      resetn   = 1'b1;
      cur_addr = 2'd0;
      idle();

      // Randomised packet traffic.
      repeat (60) begin
         n_ld    = $urandom_range(0, 5);
         wait_n  = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 4)) : 0;
         full_at = (n_ld > 0 && $urandom_range(0, 2) == 0) ? int'($urandom_range(0, n_ld - 1)) : -1;
         sr_at   = (n_ld > 0 && $urandom_range(0, 5) == 0) ? int'($urandom_range(0, n_ld - 1)) : -1;
         send_packet(2'($urandom_range(0, 2)), wait_n, n_ld, full_at,
                     $urandom_range(1, 4), 1'($urandom_range(0, 1)), sr_at,
                     1'($urandom_range(0, 3) == 0));
         if ($urandom_range(0, 3) == 0) header3($urandom_range(0, 3));
         if ($urandom_range(0, 1) == 0) idle();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
